// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART transmitter and receiver.
package uart_pkg;
    localparam int UART_CLKS_PER_BIT = 10416;
    localparam int DATA_BITS = 8;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line in, received byte and status strobes out.
interface uart_receiver_if;
    import uart_pkg::*;
    logic                 RxD;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 framing_error;
    logic                 busy;
    modport master (input RxD, output data, data_valid, framing_error, busy);
    modport slave (output RxD, input data, data_valid, framing_error, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for an asynchronous input with a configurable reset value.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (!reset) sync_q <= {2{RESET_VAL}};
        else sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver; samples mid-bit, pulses data_valid or framing_error at mid-stop-bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
    input logic clk,
    input logic reset,
    uart_receiver_if.master rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, armed_q, armed_d;
    logic [1:0]           prime_q;
    logic                 rx_s;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx.RxD),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            prime_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // prime_q keeps the synchronizer's reset-value 1s from arming the receiver while the real line is still low
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_s && prime_q[1]) armed_d = 1'b1;
                if (armed_q && !rx_s) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                state_d = RX_IDLE;
                if (rx_s) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    ferr_d  = 1'b1;
                    armed_d = 1'b0;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx.data          = data_q;
    assign rx.data_valid    = valid_q;
    assign rx.framing_error = ferr_q;
    assign rx.busy          = (state_q != RX_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames on an ideal line at 16 clocks per bit, checked against hand-computed results.
module tb_uart_receiver;
    localparam int C = 16;
    // pin edge to the registered stop-sample output: 2 sync + 1 IDLE observe + 8 + 9*16
    localparam int LAT = 155;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    int n_both = 0;
    int t;
    logic [7:0] vq[$];
    int vt[$];
    int ft[$];

    uart_receiver_if bus();

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid) begin
            vq.push_back(bus.data);
            vt.push_back(cyc);
        end
        if (bus.framing_error) ft.push_back(cyc);
        if (bus.data_valid && bus.framing_error) n_both++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.RxD = b;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        bus.RxD = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_ferr", bus.framing_error, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        t = cyc;
        send_byte(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        chk("a5_count", vq.size(), 1);
        chk("a5_data", vq[0], 8'hA5);
        chk("a5_time", vt[0] - t, LAT);
        chk("a5_port", bus.data, 8'hA5);
        chk("a5_ferr", ft.size(), 0);

        t = cyc;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        chk("b2b_count", vq.size(), 4);
        chk("b2b_d0", vq[1], 8'h00);
        chk("b2b_d1", vq[2], 8'hFF);
        chk("b2b_d2", vq[3], 8'h55);
        chk("b2b_t0", vt[1] - t, LAT);
        chk("b2b_gap1", vt[2] - vt[1], 10 * C);
        chk("b2b_gap2", vt[3] - vt[2], 10 * C);

        t = cyc;
        bus.RxD = 1'b0;
        repeat (4) @(negedge clk);
        bus.RxD = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch_busy_hi", bus.busy, 1);
        @(negedge clk);
        chk("glitch_busy_lo", bus.busy, 0);
        repeat (20) @(negedge clk);
        chk("glitch_nopulse", vq.size(), 4);
        chk("glitch_noferr", ft.size(), 0);
        send_byte(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        chk("post_glitch_count", vq.size(), 5);
        chk("post_glitch_data", vq[4], 8'h3C);

        t = cyc;
        send_byte(8'h81, 1'b0);
        repeat (50 * C) @(negedge clk);
        chk("ferr_count", ft.size(), 1);
        chk("ferr_time", ft[0] - t, LAT);
        chk("ferr_data_held", bus.data, 8'h3C);
        chk("ferr_novalid", vq.size(), 5);
        chk("ferr_idle_low", bus.busy, 0);
        bus.RxD = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h7E, 1'b1);
        repeat (20) @(negedge clk);
        chk("post_ferr_count", vq.size(), 6);
        chk("post_ferr_data", vq[5], 8'h7E);
        chk("post_ferr_ferr", ft.size(), 1);

        fork
            send_byte(8'hC3, 1'b1);
            begin
                repeat (4 * C + 8) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                chk("mid_rst_busy", bus.busy, 0);
                chk("mid_rst_data", bus.data, 8'h00);
                chk("mid_rst_valid", bus.data_valid, 0);
                chk("mid_rst_ferr", bus.framing_error, 0);
            end
        join
        repeat (20) @(negedge clk);
        chk("mid_rst_nopulse", vq.size(), 6);
        chk("mid_rst_noferr", ft.size(), 1);
        send_byte(8'h12, 1'b1);
        repeat (20) @(negedge clk);
        chk("post_rst_count", vq.size(), 7);
        chk("post_rst_data", vq[6], 8'h12);
        chk("post_rst_port", bus.data, 8'h12);
        chk("never_both", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
